// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants and types for the 2-read/1-write register file.
// DATA_W is shared with twoto1mux so the ALU-source select stays width-matched.
package reg_file_2r1w_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/reg_file_2r1w_reg_write_decoder.sv
// One-hot write strobe decoder for the register file.
// Strobes are gated by we and bit 0 is held low so the zero register never loads.
module reg_write_decoder
    import reg_file_2r1w_pkg::*;
(
    input  logic              we_i,
    input  addr_t             waddr_i,
    output logic [DEPTH-1:0]  wstrb_o
);

    always_comb begin
        wstrb_o = '0;
        if (we_i) begin
            wstrb_o[waddr_i] = 1'b1;
        end
        wstrb_o[ZERO_REG] = 1'b0;
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data onto matching reads.
module reg_file_2r1w #(
    parameter int n      = reg_file_2r1w_pkg::DATA_W,
    parameter int ADDR_W = reg_file_2r1w_pkg::ADDR_W,
    parameter int DEPTH  = reg_file_2r1w_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [n-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [n-1:0]      rdata0,
    output logic [n-1:0]      rdata1
);

    logic [n-1:0]     regs_q [DEPTH];
    logic [DEPTH-1:0] wstrb;

    reg_write_decoder u_write_decoder (
        .we_i    (we),
        .waddr_i (waddr),
        .wstrb_o (wstrb)
    );

    // Reset wins over a coincident write because the async branch is taken first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wstrb[i]) begin
                    regs_q[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rdata0 = regs_q[raddr0];
        rdata1 = regs_q[raddr1];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Forwarding is suppressed in reset so reads stay zero while rst_n is low.
        if (rst_n && we && (waddr != ADDR_W'(0))) begin
            if (raddr0 == waddr) rdata0 = wdata;
            if (raddr1 == waddr) rdata1 = wdata;
        end
`endif
    end

endmodule
